// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants, fetch FSM state type and field helpers
// Purpose: definitions shared by the fetch front end and the hazard unit.
// Contents: NOP_INSN, RESET_PC_DEFAULT, JAL/JALR opcodes, fetch_state_t,
//           rs1/rs2 field extractors.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    function automatic logic [4:0] insn_rs1(input logic [31:0] insn);
        return insn[19:15];
    endfunction

    function automatic logic [4:0] insn_rs2(input logic [31:0] insn);
        return insn[24:20];
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - single-entry {pc, insn} skid register for the fetch stage
// Purpose: parks the instruction returned by memory while decode is stalled.
// Ports: clk, reset (sync, active-high), load/clear controls (clear wins),
//        in_pc/in_insn capture data, valid/pc/insn held contents.
module fetch_skid_buf
    import pipeline_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [AWIDTH-1:0] in_pc,
    input  logic [DWIDTH-1:0] in_insn,
    output logic              valid,
    output logic [AWIDTH-1:0] pc,
    output logic [DWIDTH-1:0] insn
);

    logic              valid_q, valid_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] insn_q, insn_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            insn_d  = in_insn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            insn_q  <= DWIDTH'(NOP_INSN);
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign insn  = insn_q;

endmodule

// File: rtl/fetch_ifid_ctrl.sv
// rtl/fetch_ifid_ctrl.sv - instruction fetch PC/request generator and IF/ID pipeline register
// Purpose: drives the instruction-memory request, absorbs the 1-cycle memory
//          latency across stalls with a skid register, kills wrong-path
//          fetches on redirect, and presents the decode-stage instruction.
// Ports: clk, reset (sync, active-high); stall_if/ifid_wren/ifid_flush/redirect_pc
//        from the hazard unit; imem_req_*/imem_rsp_* memory interface;
//        f_pc, d_valid/d_pc/d_insn/d_rs1/d_rs2 decode outputs; fetch_err sticky
//        missing-response flag; perf_stall_cnt/perf_flush_cnt.
// Config: FETCH_PERF_CNT_EN enables the two perf counters (tied to 0 otherwise).
module fetch_ifid_ctrl
    import pipeline_pkg::*;
#(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_if,
    input  logic              ifid_wren,
    input  logic              ifid_flush,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic              imem_req_valid,
    output logic [AWIDTH-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DWIDTH-1:0] imem_rsp_data,
    output logic [AWIDTH-1:0] f_pc,
    output logic              d_valid,
    output logic [AWIDTH-1:0] d_pc,
    output logic [DWIDTH-1:0] d_insn,
    output logic [4:0]        d_rs1,
    output logic [4:0]        d_rs2,
    output logic              fetch_err,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
);

    fetch_state_t      state_q, state_d;
    logic [AWIDTH-1:0] f_pc_q, f_pc_d;
    logic              rsp_pending_q, rsp_pending_d;
    logic [AWIDTH-1:0] req_pc_q, req_pc_d;
    logic              d_valid_q, d_valid_d;
    logic [AWIDTH-1:0] d_pc_q, d_pc_d;
    logic [DWIDTH-1:0] d_insn_q, d_insn_d;
    logic              fetch_err_q, fetch_err_d;

    logic              req_valid;
    logic              rsp_ok;
    logic              rsp_missing;
    logic              skid_load, skid_clear;
    logic              skid_valid;
    logic [AWIDTH-1:0] skid_pc;
    logic [DWIDTH-1:0] skid_insn;

    assign req_valid   = ~reset & ~stall_if & ~ifid_flush;
    assign rsp_ok      = rsp_pending_q & imem_rsp_valid;
    assign rsp_missing = rsp_pending_q & ~imem_rsp_valid;

    fetch_skid_buf #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .in_pc   (req_pc_q),
        .in_insn (imem_rsp_data),
        .valid   (skid_valid),
        .pc      (skid_pc),
        .insn    (skid_insn)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        f_pc_d        = f_pc_q;
        rsp_pending_d = req_valid;
        req_pc_d      = req_pc_q;
        d_valid_d     = d_valid_q;
        d_pc_d        = d_pc_q;
        d_insn_d      = d_insn_q;
        fetch_err_d   = fetch_err_q | rsp_missing;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;

        if (req_valid) begin
            f_pc_d   = f_pc_q + AWIDTH'(4);
            req_pc_d = f_pc_q;
        end

        if (ifid_flush) begin
            // Redirect: kill IF/ID, the skid and whatever response lands now.
            d_valid_d  = 1'b0;
            d_pc_d     = '0;
            d_insn_d   = DWIDTH'(NOP_INSN);
            skid_clear = 1'b1;
            f_pc_d     = redirect_pc & ~AWIDTH'(3);
            state_d    = ST_RUN;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    d_valid_d = 1'b0;
                    d_pc_d    = '0;
                    d_insn_d  = DWIDTH'(NOP_INSN);
                    state_d   = ST_RUN;
                end
                ST_RUN: begin
                    if (ifid_wren) begin
                        if (rsp_ok) begin
                            d_valid_d = 1'b1;
                            d_pc_d    = req_pc_q;
                            d_insn_d  = imem_rsp_data;
                        end else begin
                            d_valid_d = 1'b0;
                            d_pc_d    = '0;
                            d_insn_d  = DWIDTH'(NOP_INSN);
                        end
                    end else if (stall_if && rsp_ok) begin
                        // Decode is frozen but memory already answered: park it.
                        skid_load = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall_if) begin
                        // Skid drains into IF/ID while the held f_pc is requested,
                        // so the next sequential instruction follows with no gap.
                        d_valid_d  = skid_valid;
                        d_pc_d     = skid_pc;
                        d_insn_d   = skid_insn;
                        skid_clear = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q        <= RESET_PC;
            rsp_pending_q <= 1'b0;
            req_pc_q      <= '0;
            d_valid_q     <= 1'b0;
            d_pc_q        <= '0;
            d_insn_q      <= DWIDTH'(NOP_INSN);
            fetch_err_q   <= 1'b0;
        end else begin
            f_pc_q        <= f_pc_d;
            rsp_pending_q <= rsp_pending_d;
            req_pc_q      <= req_pc_d;
            d_valid_q     <= d_valid_d;
            d_pc_q        <= d_pc_d;
            d_insn_q      <= d_insn_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q + {31'b0, stall_if & ~ifid_flush};
        perf_flush_cnt_d = perf_flush_cnt_q + {31'b0, ifid_flush};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = f_pc_q;
    assign f_pc           = f_pc_q;
    assign d_valid        = d_valid_q;
    assign d_pc           = d_pc_q;
    assign d_insn         = d_insn_q;
    assign d_rs1          = d_valid_q ? insn_rs1(32'(d_insn_q)) : 5'd0;
    assign d_rs2          = d_valid_q ? insn_rs2(32'(d_insn_q)) : 5'd0;
    assign fetch_err      = fetch_err_q;

endmodule

// File: tb/tb_fetch_ifid_ctrl.sv
// tb/tb_fetch_ifid_ctrl.sv - directed self-checking bench for fetch_ifid_ctrl
module tb_fetch_ifid_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC  = 32'h0100_0000;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_if, ifid_wren, ifid_flush;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] f_pc;
    logic        d_valid;
    logic [31:0] d_pc, d_insn;
    logic [4:0]  d_rs1, d_rs2;
    logic        fetch_err;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    logic        withhold;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    bit held_prev = 1'b0;

    fetch_ifid_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .stall_if       (stall_if),
        .ifid_wren      (ifid_wren),
        .ifid_flush     (ifid_flush),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .f_pc           (f_pc),
        .d_valid        (d_valid),
        .d_pc           (d_pc),
        .d_insn         (d_insn),
        .d_rs1          (d_rs1),
        .d_rs2          (d_rs2),
        .fetch_err      (fetch_err),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h02B4_C6A5;
    endfunction

    // One-cycle-latency instruction memory.
    always @(posedge clk) begin
        imem_rsp_valid <= imem_req_valid && !withhold;
        imem_rsp_data  <= mem_word(imem_req_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic [31:0] rp, input logic wh);
        stall_if    = s;
        ifid_wren   = !s;
        ifid_flush  = f;
        redirect_pc = rp;
        withhold    = wh;
    endtask

    // Scoreboard: every surviving request is pushed, every fresh IF/ID load popped.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            held_prev = 1'b0;
        end else begin
            if (!held_prev) begin
                if (d_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        logic [31:0] e;
                        logic [31:0] w;
                        e = exp_q.pop_front();
                        w = mem_word(e);
                        chk("sb_pc", d_pc, e);
                        chk("sb_insn", d_insn, w);
                        chk("sb_rs1", {27'b0, d_rs1}, {27'b0, w[19:15]});
                        chk("sb_rs2", {27'b0, d_rs2}, {27'b0, w[24:20]});
                    end
                end else begin
                    chk("sb_bubble_insn", d_insn, NOP);
                    chk("sb_bubble_rs", {22'b0, d_rs1, d_rs2}, 32'd0);
                end
            end
            if (ifid_flush) exp_q.delete();
            if (imem_req_valid && !withhold) exp_q.push_back(imem_req_addr);
            held_prev = stall_if && !ifid_flush;
        end
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        chk("rst_f_pc", f_pc, RPC);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_d_valid", {31'b0, d_valid}, 32'd0);
        chk("rst_d_pc", d_pc, 32'd0);
        chk("rst_d_insn", d_insn, NOP);
        chk("rst_rs", {22'b0, d_rs1, d_rs2}, 32'd0);
        chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
        chk("rst_perf_flush", perf_flush_cnt, 32'd0);

        // Cycle 0 after release: BOOT request at RESET_PC.
        reset = 1'b0;
        #1;
        chk("boot_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("boot_req_addr", imem_req_addr, RPC);
        tick();                                   // c1
        chk("c1_req_addr", imem_req_addr, RPC + 32'h4);
        chk("c1_d_valid", {31'b0, d_valid}, 32'd0);
        tick();                                   // c2
        chk("c2_d_valid", {31'b0, d_valid}, 32'd1);
        chk("c2_d_pc", d_pc, RPC);
        tick();                                   // c3

        // Stall c3..c5, release in c6.
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick();
        tick();
        tick();                                   // c6
        chk("stall_hold_pc", d_pc, RPC + 32'h4);
        chk("stall_hold_insn", d_insn, mem_word(RPC + 32'h4));
        chk("stall_f_pc", f_pc, RPC + 32'hC);
        chk("perf_stall_3", perf_stall_cnt, PERF_ON ? 32'd3 : 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();                                   // c7
        chk("release_skid_pc", d_pc, RPC + 32'h8);
        tick();                                   // c8
        chk("release_next_pc", d_pc, RPC + 32'hC);

        // Flush to 0x0100_0040 (low bits forced to zero).
        drive(1'b0, 1'b1, 32'h0100_0043, 1'b0);
        #1;
        chk("flush_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick();                                   // c9
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("flush_target_req", imem_req_addr, 32'h0100_0040);
        chk("flush_bubble1", {31'b0, d_valid}, 32'd0);
        tick();                                   // c10
        chk("flush_bubble2", {31'b0, d_valid}, 32'd0);
        tick();                                   // c11
        chk("flush_target_dpc", d_pc, 32'h0100_0040);
        chk("flush_target_valid", {31'b0, d_valid}, 32'd1);
        chk("perf_flush_1", perf_flush_cnt, PERF_ON ? 32'd1 : 32'd0);

        // Stall into HOLD, then flush+stall together.
        tick();                                   // c12
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();                                   // c13
        drive(1'b1, 1'b1, 32'h0100_0080, 1'b0);
        #1;
        chk("hold_flush_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick();                                   // c14
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("hold_flush_req", imem_req_addr, 32'h0100_0080);
        chk("hold_flush_bubble", {31'b0, d_valid}, 32'd0);
        chk("perf_stall_4", perf_stall_cnt, PERF_ON ? 32'd4 : 32'd0);
        chk("perf_flush_2", perf_flush_cnt, PERF_ON ? 32'd2 : 32'd0);
        tick();                                   // c15
        chk("hold_flush_bubble2", {31'b0, d_valid}, 32'd0);
        tick();                                   // c16
        chk("hold_flush_target", d_pc, 32'h0100_0080);

        // Withhold the response to the request at 0x0100_0088.
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();                                   // c17
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("err_before", {31'b0, fetch_err}, 32'd0);
        chk("err_prev_pc", d_pc, 32'h0100_0084);
        tick();                                   // c18
        chk("err_set", {31'b0, fetch_err}, 32'd1);
        chk("err_bubble", {31'b0, d_valid}, 32'd0);
        tick();                                   // c19
        chk("err_continue_pc", d_pc, 32'h0100_008C);
        tick();                                   // c20
        chk("err_sticky", {31'b0, fetch_err}, 32'd1);

        // PC wrap-around.
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();                                   // c21
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap_req_top", imem_req_addr, 32'hFFFF_FFFC);
        tick();                                   // c22
        chk("wrap_req_zero", imem_req_addr, 32'h0);
        tick();                                   // c23
        chk("wrap_d_top", d_pc, 32'hFFFF_FFFC);
        tick();                                   // c24
        chk("wrap_d_zero", d_pc, 32'h0);
        chk("perf_flush_3", perf_flush_cnt, PERF_ON ? 32'd3 : 32'd0);

        // Reset asserted mid-stall (skid occupied).
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();                                   // c25, HOLD
        reset = 1'b1;
        tick();
        chk("mid_rst_f_pc", f_pc, RPC);
        chk("mid_rst_d_valid", {31'b0, d_valid}, 32'd0);
        chk("mid_rst_err", {31'b0, fetch_err}, 32'd0);
        chk("mid_rst_perf", perf_stall_cnt | perf_flush_cnt, 32'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        chk("rerun_d_pc", d_pc, RPC);
        chk("rerun_d_valid", {31'b0, d_valid}, 32'd1);
        tick();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ifid_ctrl.md
# fetch_ifid_ctrl

Instruction-fetch front end and IF/ID pipeline register. It is the consumer of the stall/flush controls produced by the hazard unit and the producer of the decode-stage `d_rs1`/`d_rs2` fields the hazard unit reads. The block generates the PC and drives the instruction-memory request. It absorbs the one-cycle memory latency across stalls using a skid register, and kills wrong-path instructions on a taken branch or jump.

## Interface
- `RESET_PC`, default 32'h0100_0000: first fetch address after reset.
- `AWIDTH`, default 32: PC / address width.
- `DWIDTH`, default 32: instruction width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `stall_if`  in  1  hold PC and suppress the new request.
- `ifid_wren`  in  1  IF/ID register may update.
- `ifid_flush`  in  1  redirect: kill IF/ID and the in-flight fetch.
- `redirect_pc`  in  AWIDTH  target PC, qualified by `ifid_flush`.
- `imem_req_valid`  out  1  request issued this cycle.
- `imem_req_addr`  out  AWIDTH  request address (equal to `f_pc`).
- `imem_rsp_valid`  in  1  response valid; arrives exactly 1 cycle after the request.
- `imem_rsp_data`  in  DWIDTH  instruction word.
- `f_pc`  out  AWIDTH  current fetch PC.
- `d_valid`  out  1  IF/ID holds a live instruction.
- `d_pc`  out  AWIDTH  PC of `d_insn`.
- `d_insn`  out  DWIDTH  instruction; NOP when `d_valid`=0.
- `d_rs1`, `d_rs2`  out  5  `d_insn[19:15]`, `d_insn[24:20]`; 0 when `d_valid`=0.
- `fetch_err`  out  1  sticky: an expected response was missing.
- `perf_stall_cnt`, `perf_flush_cnt`  out  32  perf counters (see Configuration).

## Operation
- FSM states:
  - BOOT: first cycle after reset. Issues a request at `RESET_PC`, then goes to RUN.
  - RUN: normal fetch.
  - HOLD: stalled with a captured response in the skid register.
- `imem_req_valid` = not reset and not `stall_if` and not `ifid_flush`. `f_pc` advances by 4 on every issued request.
- A response is expected in a cycle iff a request was issued in the previous cycle (tracked as `rsp_pending`, with `req_pc` capturing the PC).
- RUN with `ifid_wren`=1: IF/ID loads `{1, req_pc, imem_rsp_data}`. If no response is pending, IF/ID loads a bubble: `d_valid`=0, `d_insn`=32'h0000_0013.
- RUN with `stall_if`=1 (`ifid_wren`=0): IF/ID holds. A pending response is written to the skid register and the FSM goes to HOLD. If no response is pending, the FSM stays in RUN.
- HOLD with `stall_if`=0: IF/ID loads from the skid register, the skid empties, a request at the held `f_pc` issues in the same cycle, and the FSM goes to RUN.
- HOLD with `stall_if`=1: everything holds.
- `ifid_flush` (any state) has priority over stall:
  - IF/ID becomes a bubble.
  - The skid clears.
  - A response arriving this cycle is discarded.
  - `f_pc` <= `redirect_pc`, no request issues this cycle, and the FSM goes to RUN.
- `rsp_pending` with `imem_rsp_valid`=0 sets `fetch_err` (cleared only by reset) and loads a bubble.
- PC arithmetic is modulo 2^AWIDTH; wrap-around is silent. `redirect_pc[1:0]` is forced to 0.

## Timing
- Reset values:
  - `f_pc`=`RESET_PC`
  - `imem_req_valid`=0
  - `d_valid`=0, `d_pc`=0, `d_insn`=32'h0000_0013, `d_rs1`=`d_rs2`=0
  - skid empty, `fetch_err`=0, counters 0, state BOOT
- Request in cycle N -> `d_insn` visible in cycle N+2 (2-cycle fetch-to-decode latency).
- Flush in cycle N -> request at the target in N+1 -> target in IF/ID at N+3. This costs 2 bubbles.
- Stall released in cycle M -> the skid instruction is in IF/ID at M+1 and the next sequential instruction at M+2. No bubble and no duplicate.
- Reset asserted mid-stall or mid-flush overrides everything within that cycle.

## Configuration
- `FETCH_PERF_CNT_EN`:
  - Defined: `perf_stall_cnt` increments each cycle `stall_if`=1 without `ifid_flush`, and `perf_flush_cnt` increments each cycle `ifid_flush`=1. Both wrap at 2^32.
  - Undefined: both outputs are tied to 0 and no counter flops exist.

## Structure
- `pipeline_pkg`: `NOP_INSN` (32'h0000_0013), `RESET_PC_DEFAULT`, the FSM state enum `fetch_state_t`, and the opcode constants shared with the hazard unit (JAL 7'b1101111, JALR 7'b1100111).
- One sub-module, `fetch_skid_buf`: a single-entry `{pc, insn}` register with load/clear/valid.

## Test plan
- Reset release, no stalls, sequential memory -> requests 0x0100_0000, 0x0100_0004, …; `d_pc` 0x0100_0000 first valid in cycle 2 after release.
- `stall_if` high for 3 cycles mid-stream -> `d_insn` held. After release: instruction at 0x0100_0008, then 0x0100_000C, in consecutive cycles, with none lost or duplicated.
- `ifid_flush` with `redirect_pc`=0x0100_0040 -> next request 0x0100_0040, `d_valid`=0 for 2 cycles, then `d_pc`=0x0100_0040.
- `ifid_flush` and `stall_if` in the same cycle while in HOLD -> skid cleared, redirect taken, `perf_stall_cnt` not incremented.
- Withhold `imem_rsp_valid` one cycle after a request -> `fetch_err`=1 (sticky), bubble in IF/ID, fetch continues.
- `f_pc`=32'hFFFF_FFFC with no stall -> next request at 0x0000_0000.
